otter_cu_fsm: RTL and testbench
===============================

OTTER_CU_FSM -- requirements
Module: otter_cu_fsm

Interface
REQ-001 The block SHALL have one parameter: IMEM_TIMEOUT, default 15, the maximum FETCH wait cycles before illegal-fetch flagging.
REQ-002 The block SHALL have these ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ir_opcode  in  7  opcode of the current instruction.
- ir_func  in  3  funct3 of the current instruction.
- intr  in  1  level interrupt request.
- mie  in  1  machine interrupt enable from CSR file.
- imem_rdy  in  1  instruction memory data valid.
- dmem_rdy  in  1  data memory read/write complete.
- pcWrite  out  1  PC update enable.
- regWrite  out  1  register file write enable.
- memRDEN1  out  1  instruction read enable.
- memRDEN2  out  1  data read enable.
- memWE2  out  1  data write enable.
- rst_out  out  1  synchronous clear to PC and register file.
- csr_WE  out  1  CSR write enable.
- int_taken  out  1  interrupt entry strobe.
- mret_exec  out  1  MRET execute strobe.
- fetch_err  out  1  sticky fetch-timeout flag.

Function
REQ-003 States SHALL be INIT, FETCH, EXEC, WB, INTR; state register is the only required storage besides the timeout counter and fetch_err.
REQ-004 INIT SHALL assert rst_out=1, all other strobes 0, and go to FETCH unconditionally after one cycle.
REQ-005 FETCH SHALL assert memRDEN1=1; stay while imem_rdy=0; go to EXEC on imem_rdy=1.
REQ-006 The FETCH wait counter (4 bits minimum, saturating) SHALL clear on FETCH entry; when it reaches IMEM_TIMEOUT with imem_rdy=0, fetch_err SHALL set and stay set until rst; FSM remains in FETCH.
REQ-007 EXEC, opcode 0000011 (load): memRDEN2=1, pcWrite=0, go to WB.
REQ-008 EXEC, opcode 0100011 (store): memWE2=1 held while dmem_rdy=0; on dmem_rdy=1 pcWrite=1 and leave EXEC.
REQ-009 EXEC, opcode 1100011 (branch): pcWrite=1, regWrite=0, single cycle.
REQ-010 EXEC, opcode 1110011, ir_func=000: mret_exec=1, pcWrite=1; ir_func in {001,010,011}: csr_WE=1, regWrite=1, pcWrite=1; other ir_func values: pcWrite=1 only.
REQ-011 EXEC, opcodes 0110111, 0010111, 1101111, 1100111, 0010011, 0110011: pcWrite=1, regWrite=1, single cycle.
REQ-012 EXEC, any other opcode: pcWrite=1, no other strobe (NOP behaviour).
REQ-013 WB SHALL hold memRDEN2=1 while dmem_rdy=0; on dmem_rdy=1 assert regWrite=1 and pcWrite=1 in that cycle and leave WB.
REQ-014 On leaving EXEC or WB, the next state SHALL be INTR if (intr && mie) in that cycle, else FETCH.
REQ-015 INTR SHALL assert int_taken=1 and pcWrite=1 for exactly one cycle, then go to FETCH.
REQ-016 An instruction completing in EXEC/WB SHALL always commit its writes before INTR is entered; no interrupt is taken from FETCH or INTR.
REQ-017 intr arriving while mie=0 SHALL be ignored, with no latching.
REQ-018 All outputs except fetch_err SHALL be combinational from state and inputs; at most one of memRDEN2/memWE2 SHALL be high per cycle.

Reset
REQ-019 rst=1 SHALL force state INIT asynchronously, clear the counter and fetch_err, and drive rst_out=1 with all other outputs 0.
REQ-020 Reset asserted mid-operation (any state, including a pending dmem access) SHALL abandon the access with no write strobe in that cycle.
REQ-021 After rst deasserts, the first cycle SHALL be INIT, then FETCH.

Structure
REQ-022 The state enum and opcode constants (LOAD, STORE, BRANCH, SYSTEM, LUI, AUIPC, JAL, JALR, OP_IMM, OP) SHALL live in the shared package otter_pkg.
REQ-023 The block SHALL be a single module with no sub-modules.

Verification
REQ-024 Release rst, imem_rdy=1, opcode 0110011 -> INIT (rst_out=1), FETCH, then EXEC with regWrite=1 and pcWrite=1, then FETCH.
REQ-025 Load, dmem_rdy low for 3 cycles in WB -> memRDEN2 high 4 cycles, regWrite=1 and pcWrite=1 only in the 4th WB cycle.
REQ-026 Store with dmem_rdy=1, intr=1, mie=1 -> memWE2=1 and pcWrite=1 in EXEC, then INTR with int_taken=1 for 1 cycle, then FETCH.
REQ-027 intr=1, mie=0 across an ADDI (0010011) -> no INTR visit; opcode 1110011 with ir_func=000 -> mret_exec=1 for 1 cycle.
REQ-028 imem_rdy held 0 for 16 cycles -> fetch_err=1 from cycle 15, stays 1 after imem_rdy rises; rst clears it.
REQ-029 rst pulsed during WB with dmem_rdy=0 -> state INIT immediately, regWrite=0, then normal FETCH.

Source files
------------

// File: rtl/otter_pkg.sv
// otter_pkg: shared state encoding and RV32I opcode constants for the OTTER control unit
package otter_pkg;

    typedef enum logic [2:0] {ST_INIT, ST_FETCH, ST_EXEC, ST_WB, ST_INTR} state_t;

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] SYSTEM = 7'b1110011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;

    // Single-cycle instructions that write rd from the ALU/immediate path
    function automatic logic writes_rd(input logic [6:0] op);
        return op inside {LUI, AUIPC, JAL, JALR, OP_IMM, OP};
    endfunction

endpackage

// File: rtl/otter_cu_fsm.sv
// otter_cu_fsm: multicycle OTTER control FSM with memory handshakes, interrupts and fetch timeout
module otter_cu_fsm
    import otter_pkg::*;
#(
    parameter int IMEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] ir_opcode,
    input  logic [2:0] ir_func,
    input  logic       intr,
    input  logic       mie,
    input  logic       imem_rdy,
    input  logic       dmem_rdy,
    output logic       pcWrite,
    output logic       regWrite,
    output logic       memRDEN1,
    output logic       memRDEN2,
    output logic       memWE2,
    output logic       rst_out,
    output logic       csr_WE,
    output logic       int_taken,
    output logic       mret_exec,
    output logic       fetch_err
);

    localparam int CW = (IMEM_TIMEOUT > 15) ? $clog2(IMEM_TIMEOUT + 1) : 4;

    state_t          r_state;
    state_t          w_next;
    state_t          w_leave;
    logic [CW-1:0]   r_cnt;
    logic            w_sat;
    logic            w_hit;
    logic            w_sys;
    logic            w_csr;

    assign w_leave = (intr && mie) ? ST_INTR : ST_FETCH;
    assign w_sat   = r_cnt == CW'(IMEM_TIMEOUT);
    assign w_hit   = r_cnt >= CW'(IMEM_TIMEOUT - 1);
    assign w_sys   = ir_opcode == SYSTEM;
    assign w_csr   = w_sys && (ir_func inside {3'b001, 3'b010, 3'b011});

    // Next-state selection; instructions finish in EXEC or WB and only then may divert to INTR
    always_comb begin
        w_next = ST_FETCH;
        case (r_state)
            ST_INIT:  w_next = ST_FETCH;
            ST_FETCH: w_next = imem_rdy ? ST_EXEC : ST_FETCH;
            ST_EXEC:  w_next = (ir_opcode == LOAD) ? ST_WB :
                               (ir_opcode == STORE && !dmem_rdy) ? ST_EXEC : w_leave;
            ST_WB:    w_next = dmem_rdy ? w_leave : ST_WB;
            ST_INTR:  w_next = ST_FETCH;
            default:  w_next = ST_INIT;
        endcase
    end

    // State, fetch-wait counter (cleared outside FETCH, saturating) and sticky timeout flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_INIT;
            r_cnt     <= '0;
            fetch_err <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (r_state != ST_FETCH) ? '0 :
                       (!imem_rdy && !w_sat) ? r_cnt + CW'(1) : r_cnt;
            if (r_state == ST_FETCH && !imem_rdy && w_hit)
                fetch_err <= 1'b1;
        end
    end

    // Strobes decoded from current state and live inputs; LOAD and STORE are exclusive so read/write never overlap
    always_comb begin
        pcWrite   = 1'b0;
        regWrite  = 1'b0;
        memRDEN1  = 1'b0;
        memRDEN2  = 1'b0;
        memWE2    = 1'b0;
        rst_out   = 1'b0;
        csr_WE    = 1'b0;
        int_taken = 1'b0;
        mret_exec = 1'b0;
        case (r_state)
            ST_INIT:  rst_out = 1'b1;
            ST_FETCH: memRDEN1 = 1'b1;
            ST_EXEC: begin
                memRDEN2  = ir_opcode == LOAD;
                memWE2    = ir_opcode == STORE;
                pcWrite   = (ir_opcode == LOAD) ? 1'b0 : (ir_opcode == STORE) ? dmem_rdy : 1'b1;
                regWrite  = writes_rd(ir_opcode) || w_csr;
                csr_WE    = w_csr;
                mret_exec = w_sys && ir_func == 3'b000;
            end
            ST_WB: begin
                memRDEN2 = 1'b1;
                regWrite = dmem_rdy;
                pcWrite  = dmem_rdy;
            end
            ST_INTR: begin
                int_taken = 1'b1;
                pcWrite   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_otter_cu_fsm.sv
// tb_otter_cu_fsm: directed scoreboard bench for the OTTER control FSM
module tb_otter_cu_fsm;
    import otter_pkg::*;

    localparam logic [9:0] PW  = 10'b1000000000;
    localparam logic [9:0] RW  = 10'b0100000000;
    localparam logic [9:0] R1  = 10'b0010000000;
    localparam logic [9:0] R2  = 10'b0001000000;
    localparam logic [9:0] WE  = 10'b0000100000;
    localparam logic [9:0] RO  = 10'b0000010000;
    localparam logic [9:0] CSR = 10'b0000001000;
    localparam logic [9:0] IT  = 10'b0000000100;
    localparam logic [9:0] MR  = 10'b0000000010;
    localparam logic [9:0] FE  = 10'b0000000001;
    localparam logic [6:0] BAD = 7'b0000000;

    typedef struct {
        string      tag;
        logic [9:0] v;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] ir_opcode = BAD;
    logic [2:0] ir_func = 3'b000;
    logic       intr = 1'b0;
    logic       mie = 1'b0;
    logic       imem_rdy = 1'b0;
    logic       dmem_rdy = 1'b0;
    logic       pcWrite, regWrite, memRDEN1, memRDEN2, memWE2;
    logic       rst_out, csr_WE, int_taken, mret_exec, fetch_err;
    logic [9:0] obs;
    exp_t       q[$];
    exp_t       e;
    int         checks = 0;
    int         failures = 0;

    otter_cu_fsm #(.IMEM_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .ir_opcode(ir_opcode), .ir_func(ir_func),
        .intr(intr), .mie(mie), .imem_rdy(imem_rdy), .dmem_rdy(dmem_rdy),
        .pcWrite(pcWrite), .regWrite(regWrite), .memRDEN1(memRDEN1),
        .memRDEN2(memRDEN2), .memWE2(memWE2), .rst_out(rst_out),
        .csr_WE(csr_WE), .int_taken(int_taken), .mret_exec(mret_exec),
        .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    assign obs = {pcWrite, regWrite, memRDEN1, memRDEN2, memWE2,
                  rst_out, csr_WE, int_taken, mret_exec, fetch_err};

    // One cycle: drive inputs after the falling edge, queue the expectation, sample and compare, advance
    task automatic step(input string tag, input logic r, input logic [6:0] op, input logic [2:0] f,
                        input logic it, input logic me, input logic ir, input logic dr, input logic [9:0] ev);
        rst = r; ir_opcode = op; ir_func = f; intr = it; mie = me; imem_rdy = ir; dmem_rdy = dr;
        q.push_back('{tag, ev});
        #1;
        e = q.pop_front();
        checks++;
        assert (obs === e.v) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.v);
        end
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        step("reset_idle",     1, STORE,  3'b000, 1, 1, 1, 0, RO);
        step("init",           0, OP,     3'b000, 0, 0, 1, 0, RO);
        step("fetch0",         0, OP,     3'b000, 0, 0, 1, 0, R1);
        step("exec_op",        0, OP,     3'b000, 0, 0, 1, 0, PW | RW);
        step("fetch1",         0, LOAD,   3'b000, 0, 0, 1, 0, R1);
        step("exec_load",      0, LOAD,   3'b000, 0, 0, 1, 0, R2);
        for (int i = 0; i < 3; i++)
            step("wb_wait",    0, LOAD,   3'b000, 0, 0, 1, 0, R2);
        step("wb_done",        0, LOAD,   3'b000, 0, 0, 1, 1, R2 | RW | PW);
        step("fetch2",         0, STORE,  3'b000, 0, 0, 1, 0, R1);
        step("store_hold",     0, STORE,  3'b000, 1, 1, 1, 0, WE);
        step("store_done",     0, STORE,  3'b000, 1, 1, 1, 1, WE | PW);
        step("intr_entry",     0, STORE,  3'b000, 1, 1, 1, 1, IT | PW);
        step("fetch_no_intr",  0, OP_IMM, 3'b000, 1, 1, 1, 0, R1);
        step("addi_masked",    0, OP_IMM, 3'b000, 1, 0, 1, 0, PW | RW);
        step("fetch_after_m",  0, SYSTEM, 3'b000, 1, 0, 1, 0, R1);
        step("mret",           0, SYSTEM, 3'b000, 0, 0, 1, 0, MR | PW);
        step("fetch_mret",     0, SYSTEM, 3'b010, 0, 0, 1, 0, R1);
        step("csrrs",          0, SYSTEM, 3'b010, 0, 0, 1, 0, CSR | RW | PW);
        step("fetch_csr",      0, SYSTEM, 3'b101, 0, 0, 1, 0, R1);
        step("sys_other",      0, SYSTEM, 3'b101, 0, 0, 1, 0, PW);
        step("fetch_sys",      0, BRANCH, 3'b000, 0, 0, 1, 0, R1);
        step("branch",         0, BRANCH, 3'b000, 0, 0, 1, 0, PW);
        step("fetch_br",       0, BAD,    3'b000, 0, 0, 1, 0, R1);
        step("nop_opcode",     0, BAD,    3'b000, 0, 0, 1, 0, PW);
        for (int i = 1; i <= 15; i++)
            step("fetch_wait",  0, OP,    3'b000, 0, 0, 0, 0, R1);
        step("fetch_timeout",  0, OP,     3'b000, 0, 0, 0, 0, R1 | FE);
        step("err_sticky_rdy", 0, OP,     3'b000, 0, 0, 1, 0, R1 | FE);
        step("err_exec",       0, OP,     3'b000, 0, 0, 1, 0, PW | RW | FE);
        step("err_fetch",      0, LOAD,   3'b000, 0, 0, 1, 0, R1 | FE);
        step("rst_clears_err", 1, LOAD,   3'b000, 0, 0, 1, 0, RO);
        step("init2",          0, LOAD,   3'b000, 0, 0, 1, 0, RO);
        step("fetch3",         0, LOAD,   3'b000, 0, 0, 1, 0, R1);
        step("exec_load2",     0, LOAD,   3'b000, 0, 0, 1, 0, R2);
        step("wb_intr",        0, LOAD,   3'b000, 1, 1, 1, 1, R2 | RW | PW);
        step("intr_after_wb",  0, LOAD,   3'b000, 1, 1, 1, 1, IT | PW);
        step("fetch4",         0, LOAD,   3'b000, 0, 0, 1, 0, R1);
        step("exec_load3",     0, LOAD,   3'b000, 0, 0, 1, 0, R2);
        step("wb_pending",     0, LOAD,   3'b000, 0, 0, 1, 0, R2);
        step("rst_in_wb",      1, LOAD,   3'b000, 0, 0, 1, 1, RO);
        step("init3",          0, LOAD,   3'b000, 0, 0, 1, 1, RO);
        step("fetch5",         0, OP,     3'b000, 0, 0, 1, 0, R1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
